// File: rtl/icache.sv
// Direct-mapped instruction cache sitting between the fetcher and the memory
// controller. Hits are served combinationally; a miss issues one line-fill
// request and installs the returned line one cycle after mem_if_done.
// Optional statistics counters (stat_hit/stat_miss) under `ICACHE_STAT_EN.
module icache #(
  parameter int LINE_BYTES = 64,
  parameter int NUM_LINES  = 16,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic                    fetch_en,
  input  logic [ADDR_W-1:0]       fetch_pc,
  output logic                    inst_valid,
  output logic [31:0]             inst,
  output logic                    mem_if_en,
  output logic [ADDR_W-1:0]       mem_if_pc,
  input  logic                    mem_if_done,
  input  logic [LINE_BYTES*8-1:0] mem_if_data
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]             stat_hit,
  output logic [31:0]             stat_miss
`endif
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                  state_q, state_d;
  logic [NUM_LINES-1:0]    valid_q;
  logic [TAG_W-1:0]        tag_q  [NUM_LINES];
  logic [LINE_BYTES*8-1:0] data_q [NUM_LINES];

  logic [IDX_W-1:0]        pc_idx;
  logic [TAG_W-1:0]        pc_tag;
  logic [LINE_BYTES*8-1:0] hit_line;
  logic                    hit;

  logic                    en_d;
  logic [ADDR_W-1:0]       pc_d;
  logic [IDX_W-1:0]        fill_idx_q, fill_idx_d;
  logic [TAG_W-1:0]        fill_tag_q, fill_tag_d;
  logic                    install;
  logic                    miss_start;

  // Instruction words are always word aligned; the low two pc bits carry nothing.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^fetch_pc[1:0];

  assign pc_idx   = fetch_pc[OFF_W +: IDX_W];
  assign pc_tag   = fetch_pc[ADDR_W-1 -: TAG_W];
  assign hit_line = data_q[pc_idx];
  assign hit      = fetch_en & valid_q[pc_idx] & (tag_q[pc_idx] == pc_tag);

  assign inst_valid = hit;

  generate
    if (OFF_W > 2) begin : g_word_sel
      logic [OFF_W-3:0] word_sel;
      assign word_sel = fetch_pc[OFF_W-1:2];
      assign inst     = hit_line[{word_sel, 5'b0} +: 32];
    end else begin : g_single_word
      assign inst = hit_line[31:0];
    end
  endgenerate

  // Next-state and fill-request decode; everything holds while rdy is low.
  always_comb begin
    state_d    = state_q;
    en_d       = mem_if_en;
    pc_d       = mem_if_pc;
    fill_idx_d = fill_idx_q;
    fill_tag_d = fill_tag_q;
    install    = 1'b0;
    miss_start = 1'b0;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (fetch_en && !hit && !rollback) begin
            miss_start = 1'b1;
            state_d    = FILL;
            en_d       = 1'b1;
            pc_d       = {fetch_pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            fill_idx_d = pc_idx;
            fill_tag_d = pc_tag;
          end
        end
        FILL: begin
          // Rollback does not abort: the controller cannot cancel a fill.
          if (mem_if_done) begin
            install = 1'b1;
            en_d    = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state, fill request and valid bits; reset drops any pending fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_if_en  <= 1'b0;
      mem_if_pc  <= '0;
      fill_idx_q <= '0;
      fill_tag_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_if_en  <= en_d;
      mem_if_pc  <= pc_d;
      fill_idx_q <= fill_idx_d;
      fill_tag_q <= fill_tag_d;
      if (install) valid_q[fill_idx_q] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (install) begin
      data_q[fill_idx_q] <= mem_if_data;
      tag_q[fill_idx_q]  <= fill_tag_q;
    end
  end

`ifdef ICACHE_STAT_EN
  // Free-running hit/miss counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hit  <= '0;
      stat_miss <= '0;
    end else begin
      if (rdy && hit) stat_hit  <= stat_hit + 32'd1;
      if (miss_start) stat_miss <= stat_miss + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache (LINE_BYTES=64, NUM_LINES=16, ADDR_W=32).
// Backing memory is a fixed function of the byte address; the reference model
// tracks which line base address each index holds.
module tb_icache;
  localparam int LB = 64;
  localparam int NL = 16;
  localparam int AW = 32;

  logic           clk = 1'b0;
  logic           rst, rdy, rollback, fetch_en, mem_if_done;
  logic [AW-1:0]  fetch_pc, mem_if_pc;
  logic           inst_valid, mem_if_en;
  logic [31:0]    inst;
  logic [LB*8-1:0] mem_if_data;
`ifdef ICACHE_STAT_EN
  logic [31:0]    stat_hit, stat_miss;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  icache #(.LINE_BYTES(LB), .NUM_LINES(NL), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .fetch_en(fetch_en), .fetch_pc(fetch_pc),
    .inst_valid(inst_valid), .inst(inst),
    .mem_if_en(mem_if_en), .mem_if_pc(mem_if_pc),
    .mem_if_done(mem_if_done), .mem_if_data(mem_if_data)
`ifdef ICACHE_STAT_EN
    , .stat_hit(stat_hit), .stat_miss(stat_miss)
`endif
  );

  // Memory contents: low byte of the address, scrambled with upper bits so
  // aliasing lines carry distinct data. Addresses below 0x400 give byte == addr.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ {a[13:10], a[17:14]} ^ {a[21:18], a[25:22]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:2], 2'b00};
    return {mem_byte(b + 32'd3), mem_byte(b + 32'd2), mem_byte(b + 32'd1), mem_byte(b)};
  endfunction

  function automatic logic [LB*8-1:0] line_of(input logic [31:0] base);
    logic [LB*8-1:0] d;
    d = '0;
    for (int i = 0; i < LB; i++) d[i*8 +: 8] = mem_byte(base + 32'(i));
    return d;
  endfunction

  // Drive all inputs just after a falling edge, then settle before sampling.
  task automatic set_in(input logic fe, input logic [31:0] pc, input logic rb,
                        input logic dn, input logic [31:0] base, input logic rd);
    @(negedge clk);
    fetch_en = fe; fetch_pc = pc; rollback = rb;
    mem_if_done = dn; mem_if_data = line_of(base); rdy = rd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; fetch_en = 1'b0;
    fetch_pc = '0; mem_if_done = 1'b0; mem_if_data = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; fetch_en = 1'b0;
    fetch_pc = '0; mem_if_done = 1'b0; mem_if_data = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (mem_if_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", mem_if_en); end
    checks++; if (mem_if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", mem_if_pc); end
`ifdef ICACHE_STAT_EN
    checks++; if (stat_hit !== 32'd0) begin errors++; $display("FAIL reset_stat_hit got=%0d exp=0", stat_hit); end
    checks++; if (stat_miss !== 32'd0) begin errors++; $display("FAIL reset_stat_miss got=%0d exp=0", stat_miss); end
`endif
    for (int i = 0; i < NL; i++) begin
      @(negedge clk);
      fetch_en = 1'b1; fetch_pc = 32'(i * LB + 4 * i);
      #1;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_invalid idx=%0d got=%b exp=0", i, inst_valid); end
    end
    @(negedge clk);
    fetch_en = 1'b0; rst = 1'b0;
  endtask

  task automatic test_basic_fill();
    set_in(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_miss got=%b exp=0", inst_valid); end
    checks++; if (mem_if_en !== 1'b0) begin errors++; $display("FAIL basic_req_early got=%b exp=0", mem_if_en); end
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
    checks++; if (mem_if_en !== 1'b1) begin errors++; $display("FAIL basic_req_en got=%b exp=1", mem_if_en); end
    checks++; if (mem_if_pc !== 32'h0) begin errors++; $display("FAIL basic_req_pc got=%h exp=0", mem_if_pc); end
    set_in(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL basic_hit got=%b exp=1", inst_valid); end
    checks++; if (inst !== 32'h03020100) begin errors++; $display("FAIL basic_inst0 got=%h exp=03020100", inst); end
    checks++; if (mem_if_en !== 1'b0) begin errors++; $display("FAIL basic_req_drop got=%b exp=0", mem_if_en); end
    set_in(1'b1, 32'h3C, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h3F3E3D3C) begin errors++; $display("FAIL basic_inst3c got=%b/%h exp=1/3f3e3d3c", inst_valid, inst); end
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (mem_if_en !== 1'b0) begin errors++; $display("FAIL basic_no_req got=%b exp=0", mem_if_en); end
  endtask

  task automatic test_eviction();
    set_in(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL evict_miss got=%b exp=0", inst_valid); end
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h400, 1'b1);
    checks++; if (mem_if_en !== 1'b1 || mem_if_pc !== 32'h400) begin errors++; $display("FAIL evict_req got=%b/%h exp=1/400", mem_if_en, mem_if_pc); end
    set_in(1'b1, 32'h404, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (inst_valid !== 1'b1 || inst !== mem_word(32'h404)) begin errors++; $display("FAIL evict_hit got=%b/%h exp=1/%h", inst_valid, inst, mem_word(32'h404)); end
    set_in(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL evict_old_gone got=%b exp=0", inst_valid); end
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (mem_if_en !== 1'b0) begin errors++; $display("FAIL evict_rb_noreq got=%b exp=0", mem_if_en); end
  endtask

  task automatic test_rollback();
    set_in(1'b1, 32'h80, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rb_miss got=%b exp=0", inst_valid); end
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (mem_if_en !== 1'b0) begin errors++; $display("FAIL rb_suppress got=%b exp=0", mem_if_en); end
    set_in(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 1'b1);
    set_in(1'b1, 32'h84, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++; if (mem_if_en !== 1'b1 || mem_if_pc !== 32'h80) begin errors++; $display("FAIL rb_req got=%b/%h exp=1/80", mem_if_en, mem_if_pc); end
    set_in(1'b1, 32'h404, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (inst_valid !== 1'b1 || inst !== mem_word(32'h404)) begin errors++; $display("FAIL fill_hit_served got=%b/%h exp=1/%h", inst_valid, inst, mem_word(32'h404)); end
    set_in(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fill_miss_waits got=%b exp=0", inst_valid); end
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 1'b1);
    checks++; if (mem_if_en !== 1'b1 || mem_if_pc !== 32'h80) begin errors++; $display("FAIL fill_req_steady got=%b/%h exp=1/80", mem_if_en, mem_if_pc); end
    set_in(1'b1, 32'h88, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (inst_valid !== 1'b1 || inst !== mem_word(32'h88)) begin errors++; $display("FAIL rb_installed got=%b/%h exp=1/%h", inst_valid, inst, mem_word(32'h88)); end
    checks++; if (mem_if_en !== 1'b0) begin errors++; $display("FAIL rb_req_drop got=%b exp=0", mem_if_en); end
  endtask

  task automatic test_rdy_hold();
    set_in(1'b1, 32'hC0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdy_miss got=%b exp=0", inst_valid); end
    set_in(1'b1, 32'h88, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (mem_if_en !== 1'b0) begin errors++; $display("FAIL rdy_noreq got=%b exp=0", mem_if_en); end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rdy_hit_comb got=%b exp=1", inst_valid); end
    set_in(1'b1, 32'hC0, 1'b0, 1'b0, 32'h0, 1'b1);
    set_in(1'b1, 32'hC0, 1'b0, 1'b1, 32'hC0, 1'b0);
    checks++; if (mem_if_en !== 1'b1 || mem_if_pc !== 32'hC0) begin errors++; $display("FAIL rdy_req got=%b/%h exp=1/c0", mem_if_en, mem_if_pc); end
    set_in(1'b1, 32'hC0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdy_no_install got=%b exp=0", inst_valid); end
    checks++; if (mem_if_en !== 1'b1) begin errors++; $display("FAIL rdy_fill_held got=%b exp=1", mem_if_en); end
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'hC0, 1'b1);
    set_in(1'b1, 32'hCC, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (inst_valid !== 1'b1 || inst !== mem_word(32'hCC)) begin errors++; $display("FAIL rdy_later_fill got=%b/%h exp=1/%h", inst_valid, inst, mem_word(32'hCC)); end
  endtask

  task automatic test_reset_mid_fill();
    set_in(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (mem_if_en !== 1'b1 || mem_if_pc !== 32'h100) begin errors++; $display("FAIL rstfill_req got=%b/%h exp=1/100", mem_if_en, mem_if_pc); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_if_en !== 1'b0) begin errors++; $display("FAIL rstfill_async_en got=%b exp=0", mem_if_en); end
    set_in(1'b1, 32'h88, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rstfill_invalid got=%b exp=0", inst_valid); end
    rst = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b1);
    set_in(1'b1, 32'h104, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rstfill_stale_done got=%b exp=0", inst_valid); end
    checks++; if (mem_if_en !== 1'b0) begin errors++; $display("FAIL rstfill_idle got=%b exp=0", mem_if_en); end
  endtask

`ifdef ICACHE_STAT_EN
  task automatic test_stats();
    do_reset();
    set_in(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b1);
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b1);
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0, 32'h0, 1'b1);
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stat_hit_seq i=%0d got=%b exp=1", i, inst_valid); end
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (stat_miss !== 32'd1) begin errors++; $display("FAIL stat_miss got=%0d exp=1", stat_miss); end
    checks++; if (stat_hit !== 32'd16) begin errors++; $display("FAIL stat_hit got=%0d exp=16", stat_hit); end
  endtask
`endif

  task automatic test_random();
    logic              mv [NL];
    logic [31:0]       mbase [NL];
    logic              pending;
    logic [31:0]       pbase, pc, base;
    logic              fe, rb, rd, dn, exp_hit;
    int                idx, nhit, nmiss;
    logic [31:0]       tags [4];
    tags[0] = 32'h0; tags[1] = 32'h1; tags[2] = 32'h2; tags[3] = 32'h3FFFFF;
    do_reset();
    for (int i = 0; i < NL; i++) begin mv[i] = 1'b0; mbase[i] = '0; end
    pending = 1'b0; pbase = '0; nhit = 0; nmiss = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      fe = ($urandom_range(0, 99) < 80);
      rb = ($urandom_range(0, 99) < 10);
      rd = ($urandom_range(0, 99) < 85);
      dn = pending ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 5);
      pc = (tags[$urandom_range(0, 3)] << 10) + (32'($urandom_range(0, 3)) << 6) + 32'($urandom_range(0, 63));
      set_in(fe, pc, rb, dn, pending ? pbase : 32'h5A5A_0000, rd);
      base = {pc[31:6], 6'b0};
      idx = int'(pc[9:6]);
      exp_hit = fe && mv[idx] && (mbase[idx] == base);
      checks++; if (inst_valid !== exp_hit) begin errors++; $display("FAIL rnd_hit cyc=%0d pc=%h got=%b exp=%b", cyc, pc, inst_valid, exp_hit); end
      if (exp_hit) begin
        checks++; if (inst !== mem_word(pc)) begin errors++; $display("FAIL rnd_inst cyc=%0d pc=%h got=%h exp=%h", cyc, pc, inst, mem_word(pc)); end
      end
      checks++; if (mem_if_en !== pending) begin errors++; $display("FAIL rnd_req_en cyc=%0d got=%b exp=%b", cyc, mem_if_en, pending); end
      if (pending) begin
        checks++; if (mem_if_pc !== pbase) begin errors++; $display("FAIL rnd_req_pc cyc=%0d got=%h exp=%h", cyc, mem_if_pc, pbase); end
      end
`ifdef ICACHE_STAT_EN
      checks++; if (stat_hit !== 32'(nhit) || stat_miss !== 32'(nmiss)) begin errors++; $display("FAIL rnd_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, stat_hit, stat_miss, nhit, nmiss); end
`endif
      @(posedge clk);
      if (rd) begin
        if (exp_hit) nhit++;
        if (pending) begin
          if (dn) begin
            mv[int'(pbase[9:6])] = 1'b1;
            mbase[int'(pbase[9:6])] = pbase;
            pending = 1'b0;
          end
        end else if (fe && !exp_hit && !rb) begin
          pending = 1'b1;
          pbase = base;
          nmiss++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_eviction();
    test_rollback();
    test_rdy_hold();
    test_reset_mid_fill();
`ifdef ICACHE_STAT_EN
    test_stats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache between the instruction fetcher and the memory controller.
- Serves word fetches combinationally on a hit.
- On a miss it requests one full line from the memory controller through its if_en/if_pc/if_done/if_data handshake, then installs that line.
- One outstanding line fill at a time; no writes, no coherence with stores.

Parameters:
- LINE_BYTES, 64, bytes per line; power of two, 4..64; must equal the controller's ICACHE_LINE_SIZ.
- NUM_LINES, 16, number of lines; power of two.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global enable; when low, all state holds.
- rollback  in  1  pipeline flush from the reorder logic.
- fetch_en  in  1  fetcher requests the instruction at fetch_pc.
- fetch_pc  in  ADDR_W  byte address; bits [1:0] ignored.
- inst_valid  out  1  hit; inst is valid this cycle.
- inst  out  32  instruction word.
- mem_if_en  out  1  line-fill request to the memory controller.
- mem_if_pc  out  ADDR_W  line-aligned fill address.
- mem_if_done  in  1  one-cycle pulse; fill data valid.
- mem_if_data  in  LINE_BYTES*8  line data; byte i at bits [8i+7:8i] is address base+i.

Behaviour:
- Address split: offset = pc[log2(LINE_BYTES)-1:0], index = next log2(NUM_LINES) bits, tag = remaining upper bits.
- Storage per line: valid bit, tag, LINE_BYTES*8 data.
- Reset: all valid bits 0, state IDLE, mem_if_en 0, mem_if_pc 0, all statistic counters 0. Data and tag arrays are not reset.
- Hit = fetch_en & valid[index] & tag match. Purely combinational.
- inst_valid = hit, in any state and regardless of rollback.
- inst = little-endian word line[index][offset*8+31 : offset*8], offset word-aligned. It is X-safe don't-care when inst_valid is 0.
- State IDLE:
  - Condition: fetch_en & !hit & !rollback & rdy.
  - Action: at the clock edge set mem_if_en<=1 and mem_if_pc<={pc[ADDR_W-1:log2(LINE_BYTES)], zeros}, latch fill index and tag, go to FILL.
  - mem_if_done is ignored in IDLE (stale pulse).
- State FILL:
  - mem_if_en and mem_if_pc hold steady until mem_if_done.
  - On an edge with mem_if_done=1: write mem_if_data, latched tag and valid=1 into the latched index; mem_if_en<=0; go to IDLE.
  - The filled line hits from the following cycle; there is no same-cycle bypass.
- Miss latency: request visible one cycle after the missing fetch; data hits one cycle after mem_if_done.
- Rollback during FILL does not abort. The memory controller cannot cancel, so the fill completes and is installed; the fetcher re-requests after redirect.
- A different fetch_pc during FILL:
  - Hits are still served.
  - Misses wait; no second request is queued.
  - The fetcher keeps fetch_en asserted and retries.
- A fill to an index currently valid with another tag overwrites it (eviction).
- rdy=0: no state, array or counter changes. Combinational hit output still reflects current contents.
- Reset mid-FILL: returns to IDLE with mem_if_en=0 asynchronously. A later mem_if_done is ignored since state is IDLE.

Optional Feature:
- Macro: ICACHE_STAT_EN.
- Defined: adds outputs stat_hit (32) and stat_miss (32), both reset to 0.
  - stat_hit increments on each edge with rdy & hit.
  - stat_miss increments on each IDLE->FILL transition.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then fetch_en, pc=0x0000_0000 -> inst_valid=0; next cycle mem_if_en=1, mem_if_pc=0x0.
- Respond with done, line bytes = i -> next cycle inst=0x03020100. Then pc=0x3C -> inst=0x3F3E3D3C, no new request.
- Fill 0x000, then fetch 0x400 (same index 0, NUM_LINES=16, LINE_BYTES=64) -> miss, request pc 0x400. After fill, 0x000 misses again.
- Miss at 0x80 with rollback=1 same cycle -> no request. Miss at 0x80, then rollback during FILL -> fill still installs; 0x80 hits afterward.
- Hold rdy=0 while mem_if_done=1 in FILL -> no install, state FILL persists. Assert rst mid-FILL -> mem_if_en=0 immediately, all lines invalid.
- ICACHE_STAT_EN defined: 1 miss + 16 hits sequence -> stat_miss=1, stat_hit=16.
